ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xF4 enable, 0xFF reset)
//  to a keyboard/mouse over the shared open-drain ps2clk/ps2data lines. Sits beside the existing ps2kbd

---
 rtl/ps2_host_tx_pkg.sv | 40 ++++
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_host_tx_line_filter.sv | 51 +++++
 rtl/ps2_host_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: host transmitter states, command bytes and
// clock-frequency based timing derivation.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_WAIT_FIRST,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_FAIL
  } state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_CMD_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // data bits + parity + stop, each presented after one device falling edge
  localparam int unsigned PS2_FALLS_OUT = 10;

  function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                               input int unsigned us);
    return (freq_hz / 1000) * us / 1000;
  endfunction

  function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                               input int unsigned ms);
    return (freq_hz / 1000) * ms;
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request / completion signals between a command source and ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_ok, error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_ok, error
  );
endinterface

// File: rtl/ps2_host_tx_line_filter.sv
// Asynchronous PS/2 line input: 2-FF synchroniser followed by a glitch filter
// that only accepts a new level after C_filter_len consecutive equal samples.
module ps2_host_tx_line_filter #(
  parameter int unsigned C_filter_len = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);
  localparam int unsigned CW = (C_filter_len > 1) ? $clog2(C_filter_len) : 1;

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(C_filter_len - 1)) begin
        level_d = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Idle bus level is high, so reset to 1 to avoid a spurious fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one
// command byte on device falling edges and report the device ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned C_clk_freq_hz = 40_000_000,
  parameter int unsigned C_inhibit_us  = 100,
  parameter int unsigned C_start_ms    = 15,
  parameter int unsigned C_packet_ms   = 2,
  parameter int unsigned C_filter_len  = 8
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2clk_i,
  input  logic         ps2data_i,
  output logic         ps2clk_oe,
  output logic         ps2data_oe
);
  localparam int unsigned C_inhibit = us_to_cycles(C_clk_freq_hz, C_inhibit_us);
  localparam int unsigned C_start   = ms_to_cycles(C_clk_freq_hz, C_start_ms);
  localparam int unsigned C_packet  = ms_to_cycles(C_clk_freq_hz, C_packet_ms);
  localparam int unsigned C_max_ip  = (C_inhibit > C_packet) ? C_inhibit : C_packet;
  localparam int unsigned C_max     = (C_start > C_max_ip) ? C_start : C_max_ip;
  localparam int unsigned TW        = $clog2(C_max + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          ack_ok_q, ack_ok_d;
  logic          error_q, error_d;
  logic          ready_q, ready_d;

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;

  ps2_host_tx_line_filter #(.C_filter_len(C_filter_len)) u_clk_filter (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2clk_i),
    .level_o(clk_lvl),
    .fall_o (clk_fall)
  );

  ps2_host_tx_line_filter #(.C_filter_len(C_filter_len)) u_data_filter (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2data_i),
    .level_o(data_lvl),
    .fall_o (data_fall_unused)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    ack_ok_d  = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx.tx_valid && ready_q) begin
          shreg_d   = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
          bit_cnt_d = '0;
          timer_d   = '0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == TW'(C_inhibit - 1)) begin
          timer_d   = '0;
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RTS: begin
        clk_oe_d = 1'b0;
        timer_d  = '0;
        state_d  = S_WAIT_FIRST;
      end
      S_WAIT_FIRST: begin
        if (clk_fall) begin
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b0, shreg_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = '0;
          state_d   = S_SHIFT;
        end else if (timer_q == TW'(C_start - 1)) begin
          state_d = S_FAIL;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_SHIFT: begin
        if (timer_q == TW'(C_packet - 1)) begin
          state_d = S_FAIL;
        end else begin
          timer_d = timer_q + TW'(1);
          if (clk_fall) begin
            data_oe_d = ~shreg_q[0];
            shreg_d   = {1'b0, shreg_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'(PS2_FALLS_OUT - 1)) state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        data_oe_d = 1'b0;
        if (timer_q == TW'(C_packet - 1)) begin
          state_d = S_FAIL;
        end else begin
          timer_d = timer_q + TW'(1);
          if (clk_fall) begin
            ack_d   = ~data_lvl;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (timer_q == TW'(C_packet - 1)) begin
          state_d = S_FAIL;
        end else begin
          timer_d = timer_q + TW'(1);
          if (clk_lvl && data_lvl) begin
            done_d   = 1'b1;
            ack_ok_d = ack_q;
            error_d  = ~ack_q;
            state_d  = S_IDLE;
          end
        end
      end
      S_FAIL: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b1;
        error_d   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      error_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      ack_ok_q  <= ack_ok_d;
      error_q   <= error_d;
      ready_q   <= ready_d;
    end
  end

  assign ps2clk_oe   = clk_oe_q;
  assign ps2data_oe  = data_oe_q;
  assign tx.tx_ready = ready_q;
  assign tx.busy     = (state_q != S_IDLE);
  assign tx.done     = done_q;
  assign tx.ack_ok   = ack_ok_q;
  assign tx.error    = error_q;

endmodule
